axil_mem_write_bridge: RTL and testbench

//  AXI4-Lite write-only slave that sits directly upstream of the unified memory's AXI-side write port.

---
 rtl/axil_mem_write_bridge.sv | 187 ++++++++++++++++++
 tb/tb_axil_mem_write_bridge.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_mem_write_bridge.sv
// axil_mem_write_bridge: AXI4-Lite write-only slave that feeds the unified memory's
// AXI-side write port. It handles one transaction at a time, range- and strobe-checks
// it against the ring window, and keeps saturating debug counters.
module axil_mem_write_bridge #(
  parameter logic [31:0] WIN_BASE = 32'hA0000100,
  parameter int unsigned WIN_SIZE = 256,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_awvalid,
  output logic             s_awready,
  input  logic [31:0]      s_awaddr,
  input  logic             s_wvalid,
  output logic             s_wready,
  input  logic [31:0]      s_wdata,
  input  logic [3:0]       s_wstrb,
  output logic             s_bvalid,
  input  logic             s_bready,
  output logic [1:0]       s_bresp,
  output logic [31:0]      axi_mem_addr,
  output logic [31:0]      axi_mem_data,
  output logic             axi_mem_w,
  output logic             busy,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Window bounds in 33 bits so the top of the address space cannot wrap.
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, WIN_BASE};
  localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(WIN_SIZE) - (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state, state_nx;

  logic                aw_held, aw_held_nx;
  logic                w_held, w_held_nx;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_nx;
  logic [DATA_W-1:0]   wdata_q, wdata_nx;
  logic [STRB_W-1:0]   wstrb_q, wstrb_nx;
  logic                legal_q, legal_nx;

  logic                awready_nx;
  logic                wready_nx;
  logic                bvalid_nx;
  logic [1:0]          bresp_nx;
  logic [ADDR_W-1:0]   mem_addr_nx;
  logic [DATA_W-1:0]   mem_data_nx;
  logic                mem_w_nx;
  logic                busy_nx;
  logic [CNT_W-1:0]    wr_count_nx;
  logic [CNT_W-1:0]    err_count_nx;

  logic                aw_fire_c;
  logic                w_fire_c;
  logic                in_window_c;

  assign aw_fire_c = s_awvalid && s_awready;
  assign w_fire_c  = s_wvalid && s_wready;

  // Window check on the address that will be held after this edge.
  assign in_window_c = ({1'b0, awaddr_nx} >= WIN_LO) && ({1'b0, awaddr_nx} <= WIN_HI);

  // Next-state and next-output logic for capture, memory write and response.
  always_comb begin
    state_nx     = state;
    aw_held_nx   = aw_held;
    w_held_nx    = w_held;
    awaddr_nx    = awaddr_q;
    wdata_nx     = wdata_q;
    wstrb_nx     = wstrb_q;
    legal_nx     = legal_q;
    bvalid_nx    = s_bvalid;
    bresp_nx     = s_bresp;
    mem_addr_nx  = axi_mem_addr;
    mem_data_nx  = axi_mem_data;
    mem_w_nx     = 1'b0;
    wr_count_nx  = wr_count;
    err_count_nx = err_count;

    unique case (state)
      IDLE: begin
        if (aw_fire_c) begin
          aw_held_nx = 1'b1;
          awaddr_nx  = s_awaddr;
        end
        if (w_fire_c) begin
          w_held_nx = 1'b1;
          wdata_nx  = s_wdata;
          wstrb_nx  = s_wstrb;
        end
        // Both beats in hand: issue the memory write in the very next cycle.
        if (aw_held_nx && w_held_nx) begin
          state_nx = WRITE;
          legal_nx = in_window_c && (wstrb_nx == 4'hF);
          if (legal_nx) begin
            mem_w_nx    = 1'b1;
            mem_addr_nx = awaddr_nx;
            mem_data_nx = wdata_nx;
            if (wr_count != '1) begin
              wr_count_nx = wr_count + CNT_W'(1);
            end
          end
        end
      end
      WRITE: begin
        state_nx  = RESP;
        bvalid_nx = 1'b1;
        bresp_nx  = legal_q ? RESP_OKAY : RESP_SLVERR;
        if (!legal_q && (err_count != '1)) begin
          err_count_nx = err_count + CNT_W'(1);
        end
      end
      RESP: begin
        // Response held until the master takes it; then the slots reopen.
        if (s_bready) begin
          state_nx   = IDLE;
          bvalid_nx  = 1'b0;
          bresp_nx   = RESP_OKAY;
          aw_held_nx = 1'b0;
          w_held_nx  = 1'b0;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    awready_nx = (state_nx == IDLE) && !aw_held_nx;
    wready_nx  = (state_nx == IDLE) && !w_held_nx;
    busy_nx    = (state_nx != IDLE) || aw_held_nx || w_held_nx;
  end

  // State, holding slots and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      legal_q      <= 1'b0;
      s_awready    <= 1'b0;
      s_wready     <= 1'b0;
      s_bvalid     <= 1'b0;
      s_bresp      <= RESP_OKAY;
      axi_mem_addr <= '0;
      axi_mem_data <= '0;
      axi_mem_w    <= 1'b0;
      busy         <= 1'b0;
      wr_count     <= '0;
      err_count    <= '0;
    end else begin
      state        <= state_nx;
      aw_held      <= aw_held_nx;
      w_held       <= w_held_nx;
      awaddr_q     <= awaddr_nx;
      wdata_q      <= wdata_nx;
      wstrb_q      <= wstrb_nx;
      legal_q      <= legal_nx;
      s_awready    <= awready_nx;
      s_wready     <= wready_nx;
      s_bvalid     <= bvalid_nx;
      s_bresp      <= bresp_nx;
      axi_mem_addr <= mem_addr_nx;
      axi_mem_data <= mem_data_nx;
      axi_mem_w    <= mem_w_nx;
      busy         <= busy_nx;
      wr_count     <= wr_count_nx;
      err_count    <= err_count_nx;
    end
  end

endmodule

// File: tb/tb_axil_mem_write_bridge.sv
// Testbench for axil_mem_write_bridge: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_axil_mem_write_bridge;

  localparam logic [31:0] BASE  = 32'hA0000100;
  localparam longint unsigned SIZE = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_awvalid, s_awready;
  logic [31:0] s_awaddr;
  logic        s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid, s_bready;
  logic [1:0]  s_bresp;
  logic [31:0] axi_mem_addr, axi_mem_data;
  logic        axi_mem_w, busy;
  logic [15:0] wr_count, err_count;

  axil_mem_write_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .axi_mem_addr(axi_mem_addr), .axi_mem_data(axi_mem_data), .axi_mem_w(axi_mem_w),
    .busy(busy), .wr_count(wr_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int          m_wr = 0;
  int          m_err = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic [63:0] mem_q[$];

  // Monitor state.
  int cyc = 0;
  int aw_n = 0, w_n = 0, aw_c = 0, w_c = 0;
  bit bv_prev = 1'b0;
  bit period_mode = 1'b0;
  bit have_prev = 1'b0;
  int prev_w = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_legal(input logic [31:0] a, input logic [3:0] s);
    longint unsigned x;
    x = longint'(a);
    return (s == 4'hF) && (x >= longint'(BASE)) && (x < longint'(BASE) + SIZE);
  endfunction

  // Observes handshakes and memory pulses just after each falling edge.
  always @(negedge clk) begin
    int lc;
    #1;
    cyc++;
    if (!rst_n) begin
      aw_n = 0; w_n = 0; bv_prev = 1'b0;
    end else begin
      if (s_awvalid && s_awready) begin aw_n++; aw_c = cyc; end
      if (s_wvalid && s_wready) begin w_n++; w_c = cyc; end
      lc = (aw_c > w_c) ? aw_c : w_c;
      if (axi_mem_w) begin
        mem_q.push_back({axi_mem_addr, axi_mem_data});
        check("lat_memw", 64'(cyc), 64'(lc + 1));
        if (period_mode && have_prev) check("period", 64'(cyc - prev_w), 64'd3);
        prev_w = cyc;
        have_prev = 1'b1;
      end
      if (s_bvalid && !bv_prev) check("lat_bvalid", 64'(cyc), 64'(lc + 2));
      if (s_bvalid && s_bready) begin
        check("aw_once", 64'(aw_n), 64'd1);
        check("w_once", 64'(w_n), 64'd1);
        aw_n = 0; w_n = 0;
      end
      bv_prev = s_bvalid;
    end
  end

  task automatic send_aw(input logic [31:0] a, input int dly);
    int n = 0;
    repeat (dly) @(negedge clk);
    s_awvalid = 1'b1; s_awaddr = a;
    while (!s_awready && n < 50) begin @(negedge clk); n++; end
    check("aw_hs_timeout", 64'(n >= 50), 64'd0);
    @(negedge clk);
    s_awvalid = 1'b0; s_awaddr = $urandom;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n = 0;
    repeat (dly) @(negedge clk);
    s_wvalid = 1'b1; s_wdata = d; s_wstrb = s;
    while (!s_wready && n < 50) begin @(negedge clk); n++; end
    check("w_hs_timeout", 64'(n >= 50), 64'd0);
    @(negedge clk);
    s_wvalid = 1'b0; s_wdata = $urandom; s_wstrb = 4'($urandom);
  endtask

  // One full transaction, then compare response, memory traffic and counters to the model.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int aw_dly, input int w_dly, input int stall);
    bit legal;
    logic [1:0] eresp;
    logic [63:0] ent;
    int n = 0;
    legal = model_legal(a, s);
    eresp = legal ? 2'b00 : 2'b10;
    fork
      send_aw(a, aw_dly);
      send_w(d, s, w_dly);
    join
    while (!s_bvalid && n < 20) begin @(negedge clk); n++; end
    check("b_timeout", 64'(n >= 20), 64'd0);
    check("busy_resp", 64'(busy), 64'd1);
    check("bresp", 64'(s_bresp), 64'(eresp));
    repeat (stall) begin
      @(negedge clk);
      check("stall_bvalid", 64'(s_bvalid), 64'd1);
      check("stall_bresp", 64'(s_bresp), 64'(eresp));
      check("stall_awready", 64'(s_awready), 64'd0);
      check("stall_wready", 64'(s_wready), 64'd0);
    end
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
    check("bvalid_drop", 64'(s_bvalid), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("awready_back", 64'(s_awready), 64'd1);
    check("wready_back", 64'(s_wready), 64'd1);
    if (legal) begin
      m_wr++; m_addr = a; m_data = d;
    end else begin
      m_err++;
    end
    check("memw_count", 64'(mem_q.size()), legal ? 64'd1 : 64'd0);
    if (mem_q.size() > 0) begin
      ent = mem_q.pop_front();
      check("memw_addr", 64'(ent[63:32]), 64'(a));
      check("memw_data", 64'(ent[31:0]), 64'(d));
    end
    mem_q.delete();
    check("wr_count", 64'(wr_count), 64'(m_wr));
    check("err_count", 64'(err_count), 64'(m_err));
    check("mem_addr_hold", 64'(axi_mem_addr), 64'(m_addr));
    check("mem_data_hold", 64'(axi_mem_data), 64'(m_data));
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  s;
    rst_n = 1'b0;
    s_awvalid = 1'b0; s_awaddr = '0;
    s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
    s_bready = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_awready", 64'(s_awready), 64'd0);
    check("rst_wready", 64'(s_wready), 64'd0);
    check("rst_bvalid", 64'(s_bvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_memw", 64'(axi_mem_w), 64'd0);
    check("rst_counts", 64'({wr_count, err_count}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_awready", 64'(s_awready), 64'd1);
    check("first_wready", 64'(s_wready), 64'd1);

    // Same-cycle legal write, then W-first with late AW.
    do_txn(32'hA0000100, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_txn(32'hA00001FE, 32'h11223344, 4'hF, 3, 0, 0);
    // Above and below the window.
    do_txn(32'hA0000200, 32'h55555555, 4'hF, 0, 1, 0);
    do_txn(32'hA00000FF, 32'h66666666, 4'hF, 1, 0, 0);
    // Bad strobe with a stalled response.
    do_txn(32'hA0000104, 32'h77777777, 4'h3, 0, 0, 5);

    // Reset right after capture discards the transaction.
    @(negedge clk);
    s_awvalid = 1'b1; s_awaddr = 32'hA0000110;
    s_wvalid = 1'b1; s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk);
    check("rstmid_memw", 64'(axi_mem_w), 64'd0);
    check("rstmid_bvalid", 64'(s_bvalid), 64'd0);
    check("rstmid_ready", 64'({s_awready, s_wready}), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_addr", 64'(axi_mem_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_wr = 0; m_err = 0; m_addr = '0; m_data = '0;
    @(negedge clk);
    check("rstrel_ready", 64'({s_awready, s_wready}), 64'h3);
    check("rstrel_counts", 64'({wr_count, err_count}), 64'd0);
    repeat (5) begin
      @(negedge clk);
      check("rstrel_quiet", 64'({s_bvalid, axi_mem_w}), 64'd0);
    end
    check("rstrel_noq", 64'(mem_q.size()), 64'd0);
    mem_q.delete();

    // Back-to-back legal writes at the minimum period.
    have_prev = 1'b0;
    period_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_txn(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0);
    end
    period_mode = 1'b0;
    check("b2b_wr_count", 64'(wr_count), 64'd10);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    a = BASE + 32'($urandom_range(0, 255));
        2:       a = BASE - 32'($urandom_range(1, 8));
        3:       a = BASE + 32'(SIZE) + 32'($urandom_range(0, 8));
        default: a = ($urandom_range(0, 1) == 0) ? $urandom : 32'hFFFFFFFF - 32'($urandom_range(0, 3));
      endcase
      s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
      do_txn(a, $urandom, s, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
